// File: rtl/ram_io_responder_if.sv
// ram_io_responder_if: memory bus plus TX/RX byte streams of the responder
interface ram_io_responder_if;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        io_buffer_full;
   modport master (
      output mem_a, mem_wr, mem_wdata, tx_ready, rx_data, rx_valid,
      input  mem_rdata, tx_data, tx_valid, io_buffer_full
   );
   modport slave (
      input  mem_a, mem_wr, mem_wdata, tx_ready, rx_data, rx_valid,
      output mem_rdata, tx_data, tx_valid, io_buffer_full
   );
endinterface

// File: rtl/ram_io_responder.sv
// ram_io_responder: byte RAM plus memory-mapped TX/RX byte FIFOs behind one bus port
module ram_io_responder #(
   parameter int ADDR_WIDTH = 17,
   parameter int FIFO_DEPTH = 8
) (
   input logic               clk_in,
   input logic               rst_in,
   input logic               rdy_in,
   ram_io_responder_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   logic [7:0]    ram_q [2**ADDR_WIDTH];
   logic [7:0]    tx_mem_q [FIFO_DEPTH];
   logic [7:0]    rx_mem_q [FIFO_DEPTH];
   logic [7:0]    ram_rd_q;
   logic [7:0]    io_rd_q, io_rd_d;
   logic          io_sel_q;
   logic [PW-1:0] tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
   logic [PW-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic          is_io, io_data, io_stat, io_rd;
   logic          tx_full, rx_full, rx_empty;
   logic          tx_push, tx_pop, rx_push, rx_pop;
   logic          unused_ok;
   assign unused_ok = &{1'b0, bus.mem_a[31:18]};
   // Address decode, FIFO push/pop qualification and next-state values
   always_comb begin
      is_io    = bus.mem_a[17:16] == 2'b11;
      io_data  = is_io && bus.mem_a[15:0] == 16'h0000;
      io_stat  = is_io && bus.mem_a[15:0] == 16'h0004;
      io_rd    = rdy_in && !bus.mem_wr;
      tx_full  = tx_cnt_q == CW'(FIFO_DEPTH);
      rx_full  = rx_cnt_q == CW'(FIFO_DEPTH);
      rx_empty = rx_cnt_q == '0;
      tx_pop   = rdy_in && tx_cnt_q != '0 && bus.tx_ready;
      tx_push  = rdy_in && bus.mem_wr && io_data && (!tx_full || tx_pop);
      rx_pop   = io_rd && io_data && !rx_empty;
      rx_push  = rdy_in && bus.rx_valid && (!rx_full || rx_pop);
      tx_rd_d  = tx_rd_q + PW'(tx_pop);
      tx_wr_d  = tx_wr_q + PW'(tx_push);
      tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
      rx_rd_d  = rx_rd_q + PW'(rx_pop);
      rx_wr_d  = rx_wr_q + PW'(rx_push);
      rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
      io_rd_d  = io_data ? (rx_empty ? 8'h00 : rx_mem_q[rx_rd_q]) :
                 io_stat ? {6'b0, rx_empty, tx_full} : 8'h00;
   end
   // Storage arrays: written only on accepted accesses, never cleared by reset
   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && !is_io) begin
         if (bus.mem_wr) ram_q[bus.mem_a[ADDR_WIDTH-1:0]] <= bus.mem_wdata;
         else ram_rd_q <= ram_q[bus.mem_a[ADDR_WIDTH-1:0]];
      end
      if (!rst_in && tx_push) tx_mem_q[tx_wr_q] <= bus.mem_wdata;
      if (!rst_in && rx_push) rx_mem_q[rx_wr_q] <= bus.rx_data;
   end
   // FIFO pointers/counts and the IO side of the read-data register
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         io_sel_q <= 1'b1;
         io_rd_q  <= '0;
         tx_rd_q  <= '0;
         tx_wr_q  <= '0;
         tx_cnt_q <= '0;
         rx_rd_q  <= '0;
         rx_wr_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (io_rd) io_sel_q <= is_io;
         if (io_rd) io_rd_q <= io_rd_d;
         tx_rd_q  <= tx_rd_d;
         tx_wr_q  <= tx_wr_d;
         tx_cnt_q <= tx_cnt_d;
         rx_rd_q  <= rx_rd_d;
         rx_wr_q  <= rx_wr_d;
         rx_cnt_q <= rx_cnt_d;
      end
   end
   assign bus.mem_rdata      = io_sel_q ? io_rd_q : ram_rd_q;
   assign bus.tx_data        = tx_mem_q[tx_rd_q];
   assign bus.tx_valid       = tx_cnt_q != '0;
   assign bus.io_buffer_full = tx_cnt_q >= CW'(FIFO_DEPTH - 2);
endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder: directed and randomized checks of the RAM/IO responder
module tb_ram_io_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rdy = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   ram_io_responder_if bus ();
   ram_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(8)) dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .bus(bus)
   );
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
      bus.mem_a = a;
      bus.mem_wr = wr;
      bus.mem_wdata = d;
   endtask

   task automatic idle();
      drive(32'h3000C, 1'b1, 8'h00);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.tx_ready = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data = 8'h00;
      do_reset();
      n_cmp++; if (bus.mem_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata got %h want 00", bus.mem_rdata); end
      n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid); end
      n_cmp++; if (bus.io_buffer_full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", bus.io_buffer_full); end
      drive(32'h30004, 1'b0, 8'h00);
      step();
      n_cmp++; if (bus.mem_rdata !== 8'h02) begin n_err++; $display("FAIL reset_status got %h want 02", bus.mem_rdata); end
   endtask

   task automatic test_ram_basic();
      drive(32'h10, 1'b1, 8'hA5);
      step();
      drive(32'h10, 1'b0, 8'h00);
      step();
      n_cmp++; if (bus.mem_rdata !== 8'hA5) begin n_err++; $display("FAIL ram_basic got %h want a5", bus.mem_rdata); end
   endtask

   task automatic test_burst();
      logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         drive(32'h100 + i, 1'b1, v[i]);
         step();
      end
      for (int i = 0; i < 4; i++) begin
         drive(32'h100 + i, 1'b0, 8'h00);
         step();
         n_cmp++; if (bus.mem_rdata !== v[i]) begin n_err++; $display("FAIL burst_%0d got %h want %h", i, bus.mem_rdata, v[i]); end
      end
      drive(32'h200, 1'b1, 8'hCC);
      step();
      n_cmp++; if (bus.mem_rdata !== 8'h44) begin n_err++; $display("FAIL write_holds_rdata got %h want 44", bus.mem_rdata); end
   endtask

   task automatic test_tx();
      logic [7:0] b [9];
      do_reset();
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         b[i] = 8'(8'h40 + i * 3);
         drive(32'h30000, 1'b1, b[i]);
         step();
         n_cmp++; if (bus.io_buffer_full !== (i >= 5)) begin n_err++; $display("FAIL tx_full_after_%0d got %b want %b", i + 1, bus.io_buffer_full, i >= 5); end
      end
      drive(32'h30004, 1'b0, 8'h00);
      step();
      n_cmp++; if (bus.mem_rdata !== 8'h03) begin n_err++; $display("FAIL tx_status_full got %h want 03", bus.mem_rdata); end
      idle();
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== b[i]) begin n_err++; $display("FAIL tx_out_%0d got %b/%h want 1/%h", i, bus.tx_valid, bus.tx_data, b[i]); end
         step();
      end
      n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_drained got %b want 0", bus.tx_valid); end
      bus.tx_ready = 1'b0;
   endtask

   task automatic test_tx_full_push_pop();
      int seen;
      do_reset();
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(32'h30000, 1'b1, 8'(i + 1));
         step();
      end
      bus.tx_ready = 1'b1;
      drive(32'h30000, 1'b1, 8'hEE);
      step();
      bus.tx_ready = 1'b0;
      n_cmp++; if (bus.tx_data !== 8'h02) begin n_err++; $display("FAIL pushpop_head got %h want 02", bus.tx_data); end
      drive(32'h30004, 1'b0, 8'h00);
      step();
      n_cmp++; if (bus.mem_rdata !== 8'h03) begin n_err++; $display("FAIL pushpop_still_full got %h want 03", bus.mem_rdata); end
      idle();
      bus.tx_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.tx_valid === 1'b1) begin
            seen++;
            if (seen == 8) begin
               n_cmp++; if (bus.tx_data !== 8'hEE) begin n_err++; $display("FAIL pushpop_last got %h want ee", bus.tx_data); end
            end
         end
         step();
      end
      n_cmp++; if (seen !== 8) begin n_err++; $display("FAIL pushpop_count got %0d want 8", seen); end
      bus.tx_ready = 1'b0;
   endtask

   task automatic test_rx();
      logic [7:0] e [3] = '{8'h5A, 8'h3C, 8'h00};
      do_reset();
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'h5A;
      step();
      bus.rx_data = 8'h3C;
      step();
      bus.rx_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(32'h30000, 1'b0, 8'h00);
         step();
         n_cmp++; if (bus.mem_rdata !== e[i]) begin n_err++; $display("FAIL rx_read_%0d got %h want %h", i, bus.mem_rdata, e[i]); end
      end
      drive(32'h30004, 1'b0, 8'h00);
      step();
      n_cmp++; if (bus.mem_rdata !== 8'h02) begin n_err++; $display("FAIL rx_status got %h want 02", bus.mem_rdata); end
   endtask

   task automatic test_hold_reset();
      drive(32'h20, 1'b1, 8'h77);
      step();
      drive(32'h20, 1'b0, 8'h00);
      step();
      n_cmp++; if (bus.mem_rdata !== 8'h77) begin n_err++; $display("FAIL hold_setup got %h want 77", bus.mem_rdata); end
      rdy = 1'b0;
      drive(32'h20, 1'b1, 8'h99);
      step();
      n_cmp++; if (bus.mem_rdata !== 8'h77) begin n_err++; $display("FAIL hold_rdata got %h want 77", bus.mem_rdata); end
      drive(32'h30000, 1'b0, 8'h00);
      step();
      n_cmp++; if (bus.mem_rdata !== 8'h77) begin n_err++; $display("FAIL hold_io_read got %h want 77", bus.mem_rdata); end
      rdy = 1'b1;
      drive(32'h20, 1'b0, 8'h00);
      step();
      n_cmp++; if (bus.mem_rdata !== 8'h77) begin n_err++; $display("FAIL hold_ram_kept got %h want 77", bus.mem_rdata); end
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(32'h30000, 1'b1, 8'(8'hB0 + i));
         step();
      end
      n_cmp++; if (bus.tx_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_tx got %b want 1", bus.tx_valid); end
      rst = 1'b1;
      rdy = 1'b0;
      drive(32'h20, 1'b0, 8'h00);
      step();
      rst = 1'b0;
      rdy = 1'b1;
      n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_tx got %b want 0", bus.tx_valid); end
      n_cmp++; if (bus.mem_rdata !== 8'h00) begin n_err++; $display("FAIL mid_reset_rdata got %h want 00", bus.mem_rdata); end
      drive(32'h20, 1'b0, 8'h00);
      step();
      n_cmp++; if (bus.mem_rdata !== 8'h77) begin n_err++; $display("FAIL ram_survives_reset got %h want 77", bus.mem_rdata); end
   endtask

   task automatic test_random();
      logic [7:0]  ramm [int];
      logic [7:0]  txq [$];
      logic [7:0]  rxq [$];
      int          pool [8];
      logic [7:0]  exp_rd, d, rxd;
      logic [31:0] a;
      logic        wr, r, tr, rv;
      int          op, k, low;
      do_reset();
      exp_rd = 8'h00;
      for (int i = 0; i < 8; i++) begin
         pool[i] = int'($urandom_range(0, 32'h1FFFF));
         d = 8'($urandom);
         drive(pool[i], 1'b1, d);
         step();
         ramm[pool[i]] = d;
      end
      for (int n = 0; n < 500; n++) begin
         op = int'($urandom_range(0, 6));
         k = int'($urandom_range(0, 7));
         r = $urandom_range(0, 9) != 0;
         tr = $urandom_range(0, 2) == 0;
         rv = $urandom_range(0, 1) == 1;
         d = 8'($urandom);
         rxd = 8'($urandom);
         a = 32'(pool[k]);
         wr = op == 0;
         if (op == 2 || op == 3) begin a = 32'h30000; wr = 1'b1; end
         if (op == 4) a = 32'h30000;
         if (op == 5) a = 32'h30004;
         if (op == 6) begin a = 32'h30008 + 4 * $urandom_range(0, 100); wr = $urandom_range(0, 1) == 1; end
         a[31:18] = 14'($urandom);
         drive(a, wr, d);
         rdy = r;
         bus.tx_ready = tr;
         bus.rx_valid = rv;
         bus.rx_data = rxd;
         low = int'(a[17:0]);
         if (r) begin
            if (!wr) exp_rd = low < 32'h30000 ? ramm[low] :
                              low == 32'h30000 ? (rxq.size() > 0 ? rxq[0] : 8'h00) :
                              low == 32'h30004 ? {6'b0, rxq.size() == 0, txq.size() == 8} : 8'h00;
            if (wr && low < 32'h30000) ramm[low] = d;
            if (tr && txq.size() > 0) void'(txq.pop_front());
            if (wr && low == 32'h30000 && txq.size() < 8) txq.push_back(d);
            if (!wr && low == 32'h30000 && rxq.size() > 0) void'(rxq.pop_front());
            if (rv && rxq.size() < 8) rxq.push_back(rxd);
         end
         step();
         n_cmp++; if (bus.mem_rdata !== exp_rd) begin n_err++; $display("FAIL rand_rdata_%0d got %h want %h", n, bus.mem_rdata, exp_rd); end
         n_cmp++; if (bus.tx_valid !== (txq.size() > 0)) begin n_err++; $display("FAIL rand_tx_valid_%0d got %b want %b", n, bus.tx_valid, txq.size() > 0); end
         n_cmp++; if (bus.io_buffer_full !== (txq.size() >= 6)) begin n_err++; $display("FAIL rand_full_%0d got %b want %b", n, bus.io_buffer_full, txq.size() >= 6); end
         if (txq.size() > 0) begin
            n_cmp++; if (bus.tx_data !== txq[0]) begin n_err++; $display("FAIL rand_tx_data_%0d got %h want %h", n, bus.tx_data, txq[0]); end
         end
      end
      rdy = 1'b1;
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_ram_basic();
      test_burst();
      test_tx();
      test_tx_full_push_pop();
      test_rx();
      test_hold_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
